// File: rtl/riscv_ctrl_pkg.sv
// Shared RISC-V control encodings: ALU control codes, opcodes, controller
// states and datapath select values.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    SLT = 3'd5
  } alu_ctrl_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    ERROR    = 4'd11
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// selects and write enables out. master = controller side.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [2:0] alu_control;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic       adr_src;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       pc_write;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero,
    output alu_control, alu_src_a, alu_src_b, result_src, imm_src,
           adr_src, ir_write, reg_write, mem_write, pc_write, instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  alu_control, alu_src_a, alu_src_b, result_src, imm_src,
           adr_src, ir_write, reg_write, mem_write, pc_write, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder shared by the single-cycle and multicycle cores.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output alu_ctrl_t  alu_control
);

  always_comb begin
    alu_control = ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ADD;
      ALUOP_SUB: alu_control = SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means SUB for R-type; addi with a negative imm sets it too
          3'b000:  alu_control = (op5 & funct7b5) ? SUB : ADD;
          3'b010:  alu_control = SLT;
          3'b110:  alu_control = OR;
          3'b111:  alu_control = AND;
          default: alu_control = ADD;
        endcase
      end
      default: alu_control = ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// datapath selects, write enables and ALU control.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_t    state, state_nxt;
  logic [1:0] alu_op;
  logic      pc_update, branch, irw, rw, mw, done;
  alu_ctrl_t alu_ctl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = FETCH;
    alu_op         = ALUOP_ADD;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_WD;
    bus.result_src = RES_ALUOUT;
    bus.adr_src    = 1'b0;
    bus.illegal    = 1'b0;
    irw            = 1'b0;
    rw             = 1'b0;
    mw             = 1'b0;
    pc_update      = 1'b0;
    branch         = 1'b0;
    done           = 1'b0;
    case (state)
      FETCH: begin
        irw = 1'b1; pc_update = 1'b1;
        bus.alu_src_b = SRCB_4; bus.result_src = RES_ALU;
        state_nxt = DECODE;
      end
      DECODE: begin
        bus.alu_src_a = SRCA_OLDPC; bus.alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECUTER;
          OP_I:         state_nxt = EXECUTEI;
          OP_BEQ:       state_nxt = BEQ;
          OP_JAL:       state_nxt = JAL;
          default: begin
            if (ILLEGAL_TRAP) state_nxt = ERROR;
            else begin state_nxt = FETCH; done = 1'b1; end
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = SRCA_A; bus.alu_src_b = SRCB_IMM;
        state_nxt = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD:  begin bus.adr_src = 1'b1; state_nxt = MEMWB; end
      MEMWB:    begin bus.result_src = RES_DATA; rw = 1'b1; done = 1'b1; end
      MEMWRITE: begin bus.adr_src = 1'b1; mw = 1'b1; done = 1'b1; end
      EXECUTER: begin
        bus.alu_src_a = SRCA_A; alu_op = ALUOP_FUNCT; state_nxt = ALUWB;
      end
      EXECUTEI: begin
        bus.alu_src_a = SRCA_A; bus.alu_src_b = SRCB_IMM; alu_op = ALUOP_FUNCT;
        state_nxt = ALUWB;
      end
      ALUWB: begin rw = 1'b1; done = 1'b1; end
      // rd <- PC+4 computed from OldPC while the target (in ALUOut) loads the PC
      JAL: begin
        bus.alu_src_a = SRCA_OLDPC; bus.alu_src_b = SRCB_4; pc_update = 1'b1;
        state_nxt = ALUWB;
      end
      BEQ: begin
        bus.alu_src_a = SRCA_A; alu_op = ALUOP_SUB; branch = 1'b1; done = 1'b1;
      end
      ERROR: begin bus.illegal = 1'b1; state_nxt = ERROR; end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.imm_src = IMM_S;
      OP_BEQ:  bus.imm_src = IMM_B;
      OP_JAL:  bus.imm_src = IMM_J;
      default: bus.imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (alu_ctl)
  );

  assign bus.alu_control = alu_ctl;

  // reset holds FETCH, whose enables must not leak out while reset is high
  assign bus.ir_write   = irw  & ~reset;
  assign bus.reg_write  = rw   & ~reset;
  assign bus.mem_write  = mw   & ~reset;
  assign bus.instr_done = done & ~reset;
  assign bus.pc_write   = (pc_update | (branch & bus.zero)) & ~reset;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle RISC-V controller FSM that sits on the driving side of the ALU.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Generates the 3-bit ALU control code, operand selects and datapath write enables.
- Consumes the ALU zero flag to resolve BEQ.
- Supports lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq and jal.

Parameters:
- ILLEGAL_TRAP, 0, 1: an unknown opcode enters the ERROR state and holds there until reset. 0: an unknown opcode returns to FETCH as a NOP.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; state forced to FETCH immediately
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU z flag (result == 0), combinational from the ALU
- alu_control  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 5=SLT
- alu_src_a  out  2  00=PC, 01=OldPC, 10=A register
- alu_src_b  out  2  00=WriteData register, 01=ImmExt, 10=constant 4
- result_src  out  2  00=ALUOut, 01=Data register, 10=ALU result
- imm_src  out  2  00=I, 01=S, 10=B, 11=J; decoded from op only
- adr_src  out  1  0=PC, 1=Result
- ir_write  out  1  instruction register and OldPC load enable
- reg_write  out  1  register file write enable
- mem_write  out  1  data memory write enable
- pc_write  out  1  pc_update | (branch & zero)
- instr_done  out  1  one-cycle pulse on the final state of each instruction
- illegal  out  1  high while in ERROR

Behaviour:
- One state register, updated on the rising edge of clk.
- All outputs are decoded combinationally from state, except:
  - alu_control, which also depends on op, funct3 and funct7b5;
  - pc_write, which also depends on zero.
- While reset is high, every enable (ir_write, reg_write, mem_write, pc_write, instr_done) is forced to 0, and the state is FETCH.
- After reset deasserts, the first rising edge performs FETCH.
- ALU decode from the internal alu_op:
  - 00 -> ADD; 01 -> SUB.
  - 10 -> decode funct3:
    - 000 -> SUB if op[5] & funct7b5, else ADD;
    - 010 -> SLT; 110 -> OR; 111 -> AND;
    - any other funct3 -> ADD.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- Per-state outputs (any field not listed is 0, alu_op = 00):
  - FETCH: ir_write, pc_update; src_a=00, src_b=10, result_src=10. Next: DECODE.
  - DECODE: src_a=01, src_b=01 (branch target computed into ALUOut).
    - lw/sw -> MEMADR; R -> EXECUTER; I -> EXECUTEI; beq -> BEQ; jal -> JAL.
    - Any other opcode -> ERROR if ILLEGAL_TRAP=1, else FETCH with instr_done=1.
  - MEMADR: src_a=10, src_b=01. Next: lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
  - MEMWB: result_src=01, reg_write, instr_done. Next: FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write, instr_done. Next: FETCH.
  - EXECUTER: src_a=10, src_b=00, alu_op=10. Next: ALUWB.
  - EXECUTEI: src_a=10, src_b=01, alu_op=10. Next: ALUWB.
  - ALUWB: result_src=00, reg_write, instr_done. Next: FETCH.
  - JAL: src_a=01, src_b=10, result_src=00, pc_update. Next: ALUWB (rd <- PC+4).
  - BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, branch, instr_done. Next: FETCH.
    - pc_write = zero in this state.
  - ERROR: illegal=1, all enables 0. Stays in ERROR until reset.
- Latencies (cycles from FETCH to the next FETCH):
  - lw 5; sw 4; R/I 4; jal 4; beq 3; illegal NOP 2.
- Reset mid-instruction: the instruction is abandoned and no partial write occurs after reset assertion.
- zero is sampled only in BEQ; it is ignored in every other state.
- Invalid state encodings recover to FETCH on the next clock.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - alu_ctrl_t enum with ADD=3'd0, SUB=3'd1, AND=3'd2, OR=3'd3, SLT=3'd5. The ALU uses the same package.
  - opcode localparams.
  - state_t enum.
  - src/result/imm select encodings.
- Sub-module alu_decoder (purely combinational: alu_op, funct3, funct7b5, op[5] -> alu_control). It is reused by the single-cycle core.
- The FSM and the imm_src decode stay in multicycle_control.

Test Plan:
- Reset high for 3 cycles, then release; op=0000011:
  - during reset, all enables are 0;
  - the state sequence is FETCH, DECODE, MEMADR, MEMREAD, MEMWB;
  - reg_write=1 only in cycle 5, together with instr_done.
- op=0110011, funct3=000, funct7b5=1:
  - EXECUTER shows alu_control=1;
  - repeat with funct7b5=0 -> alu_control=0;
  - funct3=010 -> 5; funct3=111 -> 2.
- op=0010011, funct3=000, funct7b5=1 (addi with a negative imm):
  - alu_control=0, not SUB;
  - src_b=01 in EXECUTEI.
- op=1100011:
  - with zero=1 in BEQ, pc_write=1;
  - with zero=0, pc_write=0;
  - the instruction takes 3 cycles in both cases.
- op=0100011:
  - mem_write=1 for exactly 1 cycle, in MEMWRITE, with adr_src=1;
  - reg_write stays 0 throughout.
- op=1111111:
  - ILLEGAL_TRAP=1 -> illegal stays 1 and the FSM is stuck until reset is pulsed, after which FETCH is seen;
  - ILLEGAL_TRAP=0 -> the FSM returns to FETCH after DECODE.
- Assert reset asynchronously in MEMADR: mem_write and reg_write never assert, and the state is FETCH with no clock edge.
